fft_frame_feeder: RTL and testbench
===================================

// Module: fft_frame_feeder
// PURPOSE
//  Producer side of the FFT streaming input interface. Buffers a mono audio sample stream into
//  overlapping FFT_SIZE-sample frames and streams each frame, oldest sample first, into the fft
//  block as FFT_SIZE back-to-back valid cycles. Imaginary input is always zero.
//  Sits between the audio front end and fft in the keyword-spotting datapath.
// PARAMETERS
//  DATA_WIDTH  16  sample width, signed two's complement, Q1.14 (1.0 = 16'h4000)
//  FFT_SIZE    32  frame length; power of two; must match the fft instance
//  HOP_SIZE    16  new samples between frames; 1..FFT_SIZE (elaboration-time $error otherwise)
// PORTS
//  clock         in   1           single clock, rising edge
//  reset         in   1           synchronous, active-high
//  sample_valid  in   1           audio sample present
//  sample_data   in   DATA_WIDTH  audio sample, signed
//  sample_ready  out  1           feeder accepts sample this cycle
//  fft_ready     in   1           fft.ready: fft can accept a new frame
//  fft_valid     out  1           drives fft.valid_in
//  fft_real      out  DATA_WIDTH  drives fft.data_real_in
//  fft_imag      out  DATA_WIDTH  drives fft.data_imag_in; constant 0
//  frame_start   out  1           1-cycle pulse coincident with first sample of each frame
//  frame_count   out  16          frames emitted; wraps 16'hFFFF -> 0
// BEHAVIOUR
//  - Storage: circular buffer of FFT_SIZE samples; wr_ptr, new_cnt (samples since last frame).
//  - Sample handshake: a sample is written when sample_valid && sample_ready. sample_valid while
//    sample_ready=0 is ignored; no data is written.
//  - FSM: FILL -> COLLECT -> WAIT_FFT -> STREAM -> COLLECT.
//    FILL: sample_ready=1; once FFT_SIZE samples are accepted, go to WAIT_FFT.
//    COLLECT: sample_ready=1; once new_cnt reaches HOP_SIZE, go to WAIT_FFT.
//    WAIT_FFT: sample_ready=0; on fft_ready=1, snapshot rd_base=wr_ptr (oldest sample),
//      clear new_cnt and go to STREAM.
//    STREAM: sample_ready=0; emit rd_base+k mod FFT_SIZE for k=0..FFT_SIZE-1 on consecutive
//      cycles, with no gaps. A drop of fft_ready mid-frame does not pause the stream. After
//      k=FFT_SIZE-1, go to COLLECT.
//  - Latency: the first fft_valid is the cycle after fft_ready is sampled high in WAIT_FFT
//    (+1 cycle with FRAME_WINDOW_EN). All outputs are registered.
//  - frame_start and the frame_count increment both occur on the k=0 output cycle.
//  - When fft_valid=0, fft_real=0.
//  - Pointer arithmetic is modulo FFT_SIZE (natural wrap of a $clog2(FFT_SIZE)-bit counter).
//  - HOP_SIZE==FFT_SIZE gives no overlap; HOP_SIZE=1 emits a frame every new sample.
//  - Reset values: sample_ready=0, fft_valid=0, fft_real=0, fft_imag=0, frame_start=0,
//    frame_count=0; state=FILL, wr_ptr=0, new_cnt=0.
//  - Reset in any state, including mid-STREAM: outputs return to reset values on the next edge.
//    The partial frame is abandoned and a full FFT_SIZE refill is required. Buffer RAM contents
//    need not be cleared.
// CONFIGURATION
//  FRAME_WINDOW_EN defined:
//    - Each streamed sample is multiplied by a Hann coefficient w[k] (Q1.14, w[k] <= 16'h4000)
//      from a constant ROM.
//    - result = (x*w + 2^13) >>> 14, kept as 32-bit intermediate. No saturation is needed
//      because |w| <= 1.0.
//    - One extra pipeline stage. fft_valid and frame_start are delayed to match; the stream
//      stays contiguous.
//  FRAME_WINDOW_EN undefined: raw samples are passed; no ROM or multiplier is built.
// STRUCTURE
//  - Package kws_fft_pkg: DATA_WIDTH/FFT_SIZE defaults, Q14_ONE=16'h4000,
//    feeder_state_e {FILL,COLLECT,WAIT_FFT,STREAM}, and the Hann coefficient table constant.
//  - Sub-module fft_window_rom (index -> Q1.14 coefficient, registered output). Instantiated
//    only under FRAME_WINDOW_EN.
//  - Buffer: inferred dual-port array (1 write, 1 registered read).
// TESTING
//  1. Ramp 0,1,..,31 with fft_ready=1, HOP=16 -> 32 contiguous fft_valid cycles carrying
//     0..31, fft_imag=0, frame_start on value 0, frame_count=1.
//  2. Continue the ramp with 32..47 -> second frame carries 16..47, frame_count=2.
//     sample_ready=0 throughout each STREAM.
//  3. Frame pending with fft_ready=0 for 20 cycles -> fft_valid stays 0, sample_ready=0,
//     offered samples ignored; fft_ready=1 -> fft_valid rises the next cycle.
//  4. Reset pulsed at output index 10 -> next cycle fft_valid=0, fft_real=0, frame_count=0;
//     31 new samples produce no frame, the 32nd does.
//  5. fft_ready dropped at output index 5 -> all 32 samples still emitted back-to-back.
//  6. FRAME_WINDOW_EN, DC input 16'h4000 -> output k equals w[k]: k=0 -> 0,
//     k=16 -> 16'h4000 (+/-1 LSB); latency one cycle longer than in case 1.

Source files
------------

// File: rtl/kws_fft_pkg.sv
// Shared definitions for the keyword-spotting FFT front end: default sizes, Q1.14 unity,
// feeder FSM states and the Hann window coefficient table used by fft_window_rom.
package kws_fft_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int FFT_SIZE_DEF   = 32;
    localparam int HOP_SIZE_DEF   = 16;

    localparam logic [15:0] Q14_ONE = 16'h4000;

    typedef enum logic [1:0] {
        FILL,
        COLLECT,
        WAIT_FFT,
        STREAM
    } feeder_state_e;

    // Periodic Hann window w[k] = 0.5*(1 - cos(2*pi*k/32)) in Q1.14, rounded to nearest.
    localparam int HANN_LEN = 32;
    localparam logic [15:0] HANN_TABLE [HANN_LEN] = '{
        16'd0,     16'd157,   16'd624,   16'd1381,  16'd2399,  16'd3641,  16'd5057,  16'd6594,
        16'd8192,  16'd9790,  16'd11327, 16'd12743, 16'd13985, 16'd15003, 16'd15760, 16'd16227,
        16'd16384, 16'd16227, 16'd15760, 16'd15003, 16'd13985, 16'd12743, 16'd11327, 16'd9790,
        16'd8192,  16'd6594,  16'd5057,  16'd3641,  16'd2399,  16'd1381,  16'd624,   16'd157
    };

endpackage

// File: rtl/fft_window_rom.sv
// Hann coefficient ROM: frame index in, Q1.14 coefficient out one cycle later.
// Only instantiated by fft_frame_feeder when FRAME_WINDOW_EN is defined.
module fft_window_rom
    import kws_fft_pkg::*;
#(
    parameter int FFT_SIZE = FFT_SIZE_DEF,
    localparam int AW      = $clog2(FFT_SIZE)
) (
    input  logic          clock,
    input  logic [AW-1:0] index,
    output logic [15:0]   coef
);

    if (FFT_SIZE != HANN_LEN) begin : g_bad_size
        $error("fft_window_rom: Hann table holds %0d entries, FFT_SIZE is %0d", HANN_LEN, FFT_SIZE);
    end

    always_ff @(posedge clock) begin
        coef <= HANN_TABLE[index];
    end

endmodule

// File: rtl/fft_frame_feeder.sv
// Buffers an audio sample stream into overlapping FFT_SIZE frames and streams each frame,
// oldest sample first, into the fft block. Optional Hann windowing under FRAME_WINDOW_EN.
module fft_frame_feeder
    import kws_fft_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FFT_SIZE   = FFT_SIZE_DEF,
    parameter int HOP_SIZE   = HOP_SIZE_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_data,
    output logic                  sample_ready,
    input  logic                  fft_ready,
    output logic                  fft_valid,
    output logic [DATA_WIDTH-1:0] fft_real,
    output logic [DATA_WIDTH-1:0] fft_imag,
    output logic                  frame_start,
    output logic [15:0]           frame_count
);

    localparam int AW = $clog2(FFT_SIZE);
    localparam int CW = $clog2(FFT_SIZE + 1);

    if (HOP_SIZE < 1 || HOP_SIZE > FFT_SIZE) begin : g_bad_hop
        $error("fft_frame_feeder: HOP_SIZE %0d outside 1..%0d", HOP_SIZE, FFT_SIZE);
    end
    if ((FFT_SIZE & (FFT_SIZE - 1)) != 0) begin : g_bad_fft
        $error("fft_frame_feeder: FFT_SIZE %0d is not a power of two", FFT_SIZE);
    end

    feeder_state_e state, next_state;

    logic [DATA_WIDTH-1:0] mem [FFT_SIZE];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_base;
    logic [AW-1:0]         idx;
    logic [AW-1:0]         rd_addr;
    logic [CW-1:0]         new_cnt;
    logic                  accept;
    logic                  start_now;
    logic                  emit;
    logic                  ready_next;

    logic                  raw_valid;
    logic                  raw_start;
    logic [DATA_WIDTH-1:0] raw_data;

    always_comb begin
        accept     = sample_valid && sample_ready;
        start_now  = (state == WAIT_FFT) && fft_ready;
        // idx wraps to 0 after the last sample, which is also the end-of-frame marker
        emit       = start_now || ((state == STREAM) && (idx != '0));
        rd_addr    = (state == WAIT_FFT) ? wr_ptr : rd_base + idx;
        next_state = state;
        case (state)
            FILL:     if (accept && new_cnt == CW'(FFT_SIZE - 1)) next_state = WAIT_FFT;
            COLLECT:  if (accept && new_cnt == CW'(HOP_SIZE - 1)) next_state = WAIT_FFT;
            WAIT_FFT: if (fft_ready) next_state = STREAM;
            STREAM:   if (idx == '0) next_state = COLLECT;
            default:  next_state = FILL;
        endcase
        ready_next = (next_state == FILL) || (next_state == COLLECT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= FILL;
            sample_ready <= 1'b0;
        end else begin
            state        <= next_state;
            sample_ready <= ready_next;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            mem[wr_ptr] <= sample_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_base   <= '0;
            idx       <= '0;
            new_cnt   <= '0;
            raw_valid <= 1'b0;
            raw_start <= 1'b0;
            raw_data  <= '0;
        end else begin
            if (accept) begin
                wr_ptr  <= wr_ptr + AW'(1);
                new_cnt <= new_cnt + CW'(1);
            end
            if (start_now) begin
                rd_base <= wr_ptr;
                new_cnt <= '0;
                idx     <= AW'(1);
            end else if (state == STREAM && idx != '0) begin
                idx <= idx + AW'(1);
            end
            raw_valid <= emit;
            raw_start <= start_now;
            raw_data  <= emit ? mem[rd_addr] : '0;
        end
    end

    assign fft_imag = '0;

`ifdef FRAME_WINDOW_EN
    logic [AW-1:0]      emit_k;
    logic [15:0]        coef;
    logic signed [31:0] prod;

    assign emit_k = (state == WAIT_FFT) ? '0 : idx;

    fft_window_rom #(.FFT_SIZE(FFT_SIZE)) u_rom (
        .clock (clock),
        .index (emit_k),
        .coef  (coef)
    );

    always_comb begin
        prod = 32'(signed'(raw_data)) * signed'(32'(coef));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fft_valid   <= 1'b0;
            frame_start <= 1'b0;
            fft_real    <= '0;
            frame_count <= '0;
        end else begin
            fft_valid   <= raw_valid;
            frame_start <= raw_start;
            fft_real    <= raw_valid ? DATA_WIDTH'((prod + 32'sd8192) >>> 14) : '0;
            if (raw_start) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end
`else
    assign fft_valid   = raw_valid;
    assign frame_start = raw_start;
    assign fft_real    = raw_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_count <= '0;
        end else if (start_now) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Self-checking bench for fft_frame_feeder (default build): frames are compared against the
// last 32 accepted samples held in a reference queue.
module tb_fft_frame_feeder;

    localparam int DW = 16;
    localparam int N  = 32;
    localparam int H  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          sample_valid;
    logic [DW-1:0] sample_data;
    logic          sample_ready;
    logic          fft_ready;
    logic          fft_valid;
    logic [DW-1:0] fft_real;
    logic [DW-1:0] fft_imag;
    logic          frame_start;
    logic [15:0]   frame_count;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;
    logic [DW-1:0] hist [$];

    fft_frame_feeder #(.DATA_WIDTH(DW), .FFT_SIZE(N), .HOP_SIZE(H)) dut (
        .clock        (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .fft_ready    (fft_ready),
        .fft_valid    (fft_valid),
        .fft_real     (fft_real),
        .fft_imag     (fft_imag),
        .frame_start  (frame_start),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offers one sample and waits until it is taken; returns on the negedge after acceptance.
    task automatic push(input logic [DW-1:0] v);
        int unsigned tries = 0;
        sample_valid = 1'b1;
        sample_data  = v;
        while (sample_ready !== 1'b1 && tries < 200) begin
            @(negedge clk);
            tries++;
        end
        if (sample_ready !== 1'b1) begin
            check("push_timeout", 32'd0, 32'd1);
            sample_valid = 1'b0;
            return;
        end
        hist.push_back(v);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic push_ramp(input int first, input int count);
        for (int i = 0; i < count; i++) push(DW'(first + i));
    endtask

    task automatic push_rand(input int count);
        for (int i = 0; i < count; i++) push(DW'($urandom));
    endtask

    // Expected frame = the most recent N accepted samples, oldest first.
    task automatic expect_frame(input int exp_count, input int exp_wait,
                                input int drop_at, input int reset_at);
        int waits = 0;
        int base  = hist.size() - N;
        while (fft_valid !== 1'b1 && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (fft_valid !== 1'b1) begin
            check("frame_timeout", 32'd0, 32'd1);
            return;
        end
        if (exp_wait >= 0) check("latency", 32'(waits), 32'(exp_wait));
        for (int k = 0; k < N; k++) begin
            if (k == reset_at) begin
                reset = 1'b1;
                return;
            end
            if (k == drop_at) fft_ready = 1'b0;
            check("fft_valid", 32'(fft_valid), 32'd1);
            check("fft_real", 32'(fft_real), 32'(hist[base + k]));
            check("fft_imag", 32'(fft_imag), 32'd0);
            check("frame_start", 32'(frame_start), (k == 0) ? 32'd1 : 32'd0);
            check("frame_count", 32'(frame_count), 32'(exp_count));
            check("ready_in_stream", 32'(sample_ready), 32'd0);
            @(negedge clk);
        end
        check("valid_after_frame", 32'(fft_valid), 32'd0);
        check("real_after_frame", 32'(fft_real), 32'd0);
        fft_ready = 1'b1;
    endtask

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_data  = '0;
        fft_ready    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(sample_ready), 32'd0);
        check("rst_valid", 32'(fft_valid), 32'd0);
        check("rst_real", 32'(fft_real), 32'd0);
        check("rst_imag", 32'(fft_imag), 32'd0);
        check("rst_start", 32'(frame_start), 32'd0);
        check("rst_count", 32'(frame_count), 32'd0);
        reset = 1'b0;

        // Ramp fill, then one hop of ramp continuation
        push_ramp(0, N);
        expect_frame(1, 1, -1, -1);
        push_ramp(N, H);
        expect_frame(2, 1, -1, -1);

        // Frame held back by fft_ready=0; offered samples must be ignored
        fft_ready = 1'b0;
        push_rand(H);
        sample_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sample_data = DW'($urandom);
            check("held_valid", 32'(fft_valid), 32'd0);
            check("held_ready", 32'(sample_ready), 32'd0);
            @(negedge clk);
        end
        sample_valid = 1'b0;
        fft_ready    = 1'b1;
        @(negedge clk);
        expect_frame(3, 0, -1, -1);

        // Reset in the middle of a frame, then a full refill is needed
        push_rand(H);
        expect_frame(4, 1, -1, 10);
        @(negedge clk);
        check("midrst_valid", 32'(fft_valid), 32'd0);
        check("midrst_real", 32'(fft_real), 32'd0);
        check("midrst_count", 32'(frame_count), 32'd0);
        check("midrst_ready", 32'(sample_ready), 32'd0);
        reset = 1'b0;
        hist.delete();
        push_rand(N - 1);
        for (int i = 0; i < 10; i++) begin
            check("partial_valid", 32'(fft_valid), 32'd0);
            check("partial_ready", 32'(sample_ready), 32'd1);
            @(negedge clk);
        end
        push_rand(1);
        expect_frame(1, 1, -1, -1);

        // fft_ready dropped mid-frame must not pause the stream
        push_rand(H);
        expect_frame(2, 1, 5, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
